uart_rx_fifo: RTL and testbench

Buffered UART receiver for the far end of the board's serial link. It accepts the 8N2 frames produced by the transmit path, using 16x oversampling, and validates start and stop bits. Received bytes are queued in a small FIFO and handed to the consuming logic over a valid/ready interface. It replaces direct single-byte `rx_done` strobes where the consumer cannot accept a byte on every frame.

---
 rtl/uart_pkg.sv | 23 ++
 rtl/uart_rx_fifo_if.sv | 26 ++
 rtl/uart_rx_fifo_byte_fifo.sv | 49 ++++
 rtl/uart_rx_fifo.sv | 171 +++++++++++++++++
 tb/tb_uart_rx_fifo.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, oversampling ratio and the
// default clock/baud constants used by both the transmit and receive paths.
package uart_pkg;

    localparam int OVERSAMPLE  = 16;
    localparam int CLKFREQ_DEF = 100_000_000;
    localparam int BAUD_DEF    = 115_200;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        WAIT_HIGH
    } rx_state_e;

    // Clocks per oversampling tick (truncating division).
    function automatic int tick_div(int clkfreq, int baud);
        return clkfreq / (baud * OVERSAMPLE);
    endfunction

endpackage

// File: rtl/uart_rx_fifo_if.sv
// Consumer-side interface of the buffered UART receiver: byte stream with
// valid/ready handshake, FIFO occupancy and the error pulses.
interface uart_rx_fifo_if #(
    parameter int DEPTH = 4
) ();

    localparam int CW = $clog2(DEPTH) + 1;

    logic [7:0]    dout_o;
    logic          valid_o;
    logic          ready_i;
    logic [CW-1:0] count_o;
    logic          frame_err_o;
    logic          overrun_o;

    modport master (
        output dout_o, valid_o, count_o, frame_err_o, overrun_o,
        input  ready_i
    );

    modport slave (
        input  dout_o, valid_o, count_o, frame_err_o, overrun_o,
        output ready_i
    );

endinterface

// File: rtl/uart_rx_fifo_byte_fifo.sv
// Small synchronous byte FIFO. A push while full is accepted only when a pop
// frees the slot on the same edge; a pop while empty is ignored.
module byte_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push_i,
    input  logic [7:0]             din_i,
    input  logic                   pop_i,
    output logic [7:0]             dout_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [CW-1:0] cnt_q;
    logic          do_push, do_pop;

    assign full_o  = (cnt_q == CW'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign dout_o  = mem_q[rd_q];
    assign count_o = cnt_q;

    // Storage, pointers (wrap modulo DEPTH) and occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_q] <= din_i;
                wr_q        <= wr_q + AW'(1);
            end
            if (do_pop) rd_q <= rd_q + AW'(1);
            cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// Buffered 16x-oversampling UART receiver (8 data bits, 1 or 2 stop bits)
// feeding a byte FIFO with a valid/ready output.
// Optional build macro UART_RX_PARITY_EN adds an even-parity bit between the
// data and stop bits; a parity mismatch discards the byte as a frame error.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int clkfreq  = CLKFREQ_DEF,
    parameter int baudrate = BAUD_DEF,
    parameter int stopbit  = 2,
    parameter int DEPTH    = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           rx_i,
    uart_rx_fifo_if.master bus
);

    localparam int DIV = tick_div(clkfreq, baudrate);
    localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;

    logic          sync1_q, sync2_q, rx_s;
    rx_state_e     state_q, state_d;
    logic [DW-1:0] div_q, div_d;
    logic [3:0]    tck_q, tck_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    sh_q, sh_d;
    logic          push_q, push_d;
    logic          ferr_q, ferr_d;
    logic          ovr_q, ovr_d;
`ifdef UART_RX_PARITY_EN
    logic          par_bad_q, par_bad_d;
`endif
    logic          tick, mid_bit, pop, full, empty;

    assign rx_s    = sync2_q;
    assign tick    = (div_q == DW'(DIV - 1));
    // Bit-centre sample: 16 ticks after the previous one.
    assign mid_bit = tick && (tck_q == 4'd15);
    assign pop     = bus.valid_o && bus.ready_i;

    // Next-state logic: divider, tick counter, bit sequencing and push/error.
    always_comb begin
        state_d = state_q;
        div_d   = tick ? '0 : div_q + DW'(1);
        tck_d   = tick ? tck_q + 4'd1 : tck_q;
        bit_d   = bit_q;
        sh_d    = sh_q;
        push_d  = 1'b0;
        ferr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_d = par_bad_q;
`endif
        case (state_q)
            IDLE: begin
                // Holding the divider at zero restarts it on the start edge.
                div_d = '0;
                tck_d = '0;
                bit_d = '0;
`ifdef UART_RX_PARITY_EN
                par_bad_d = 1'b0;
`endif
                if (!rx_s) state_d = START;
            end
            START: begin
                if (tick && tck_q == 4'd7) begin
                    tck_d   = '0;
                    state_d = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (mid_bit) begin
                    sh_d  = {rx_s, sh_q[7:1]};
                    bit_d = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        bit_d = '0;
`ifdef UART_RX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (mid_bit) begin
                    par_bad_d = rx_s ^ (^sh_q);
                    state_d   = STOP;
                end
            end
`endif
            STOP: begin
                if (mid_bit) begin
                    bit_d = bit_q + 3'd1;
                    if (!rx_s) begin
                        ferr_d  = 1'b1;
                        state_d = WAIT_HIGH;
                    end else if (bit_q == 3'(stopbit - 1)) begin
                        state_d = IDLE;
`ifdef UART_RX_PARITY_EN
                        ferr_d  = par_bad_q;
                        push_d  = !par_bad_q;
`else
                        push_d  = 1'b1;
`endif
                    end
                end
            end
            WAIT_HIGH: begin
                if (rx_s) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Overrun: a good byte arrives while full and nothing leaves this cycle.
    assign ovr_d = push_q && full && !pop;

    // Synchronizer, FSM and pulse registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            state_q <= IDLE;
            div_q   <= '0;
            tck_q   <= '0;
            bit_q   <= '0;
            sh_q    <= '0;
            push_q  <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad_q <= 1'b0;
`endif
        end else begin
            sync1_q <= rx_i;
            sync2_q <= sync1_q;
            state_q <= state_d;
            div_q   <= div_d;
            tck_q   <= tck_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
            push_q  <= push_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
`ifdef UART_RX_PARITY_EN
            par_bad_q <= par_bad_d;
`endif
        end
    end

    // The shift register is stable until the next frame's data bits, so it
    // doubles as the push data one clock after the last stop sample.
    byte_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push_q),
        .din_i   (sh_q),
        .pop_i   (pop),
        .dout_o  (bus.dout_o),
        .full_o  (full),
        .empty_o (empty),
        .count_o (bus.count_o)
    );

    assign bus.valid_o     = !empty;
    assign bus.frame_err_o = ferr_q;
    assign bus.overrun_o   = ovr_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed + randomized bench for uart_rx_fifo. The reference model is a
// queue of bytes expected at the consumer, built from frame-level rules.
module tb_uart_rx_fifo;

    localparam int CLKF   = 100_000_000;
    localparam int BAUD   = 1_000_000;
    localparam int STOPB  = 2;
    localparam int DEPTH  = 4;
    localparam int BITCLK = (CLKF / (BAUD * 16)) * 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rx_i = 1'b1;

    uart_rx_fifo_if #(.DEPTH(DEPTH)) bus ();

    uart_rx_fifo #(
        .clkfreq(CLKF), .baudrate(BAUD), .stopbit(STOPB), .DEPTH(DEPTH)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .rx_i (rx_i),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];
    int ferr_n = 0, ovr_n = 0, long_n = 0, hold_bad = 0, max_cnt = 0;
    logic ferr_prev = 1'b0, ovr_prev = 1'b0, hold_prev = 1'b0;
    logic [7:0] dout_prev = '0;
    bit done;

    // Consumer-side monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (bus.valid_o === 1'b1 && bus.ready_i === 1'b1) got_q.push_back(bus.dout_o);
        if (bus.frame_err_o === 1'b1) ferr_n++;
        if (bus.overrun_o === 1'b1) ovr_n++;
        if ((bus.frame_err_o === 1'b1 && ferr_prev) || (bus.overrun_o === 1'b1 && ovr_prev)) long_n++;
        if (hold_prev && bus.valid_o === 1'b1 && bus.dout_o !== dout_prev) hold_bad++;
        if (bus.count_o !== 'x && int'(bus.count_o) > max_cnt) max_cnt = int'(bus.count_o);
        ferr_prev = (bus.frame_err_o === 1'b1);
        ovr_prev  = (bus.overrun_o === 1'b1);
        hold_prev = (bus.valid_o === 1'b1 && bus.ready_i === 1'b0);
        dout_prev = bus.dout_o;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Compare everything the consumer popped against the model, then clear.
    task automatic chk_stream(input string tag);
        chk($sformatf("%s.n", tag), got_q.size(), exp_q.size());
        foreach (exp_q[i])
            chk($sformatf("%s[%0d]", tag, i), (i < got_q.size()) ? 32'(got_q[i]) : 32'hxxxx_xxxx, exp_q[i]);
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic line(input logic v, input int n);
        rx_i = v;
        wait_clk(n);
    endtask

    // One frame: start, 8 data LSB first, [even parity], two stop bits.
    task automatic send(input logic [7:0] b, input bit bad_stop2 = 0, input bit bad_par = 0);
        line(1'b0, BITCLK);
        for (int i = 0; i < 8; i++) line(b[i], BITCLK);
`ifdef UART_RX_PARITY_EN
        line((^b) ^ bad_par, BITCLK);
`else
        if (bad_par) line(1'b1, 0);
`endif
        line(1'b1, BITCLK);
        line(!bad_stop2, BITCLK);
    endtask

    initial begin
        int f0, o0;
        logic [7:0] b;

        bus.ready_i = 1'b0;
        wait_clk(3);
        chk("rst.dout", bus.dout_o, 8'h00);
        chk("rst.valid", bus.valid_o, 1'b0);
        chk("rst.count", bus.count_o, 0);
        chk("rst.ferr", bus.frame_err_o, 1'b0);
        chk("rst.ovr", bus.overrun_o, 1'b0);
        rst = 1'b0;
        wait_clk(20);

        // Single byte, consumer always ready.
        bus.ready_i = 1'b1;
        max_cnt = 0;
        exp_q.push_back(8'hA5);
        send(8'hA5);
        wait_clk(40);
        chk_stream("a5");
        chk("a5.maxcnt", max_cnt, 1);
        chk("a5.count", bus.count_o, 0);
        chk("a5.ferr", ferr_n, 0);
        chk("a5.ovr", ovr_n, 0);

        // Five frames into a stalled consumer: first DEPTH kept, rest overrun.
        bus.ready_i = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            if (i <= DEPTH) exp_q.push_back(8'(i));
            send(8'(i));
        end
        wait_clk(40);
        chk("ovr.count", bus.count_o, DEPTH);
        chk("ovr.pulses", ovr_n, 5 - DEPTH);
        chk("ovr.dout", bus.dout_o, 8'h01);
        wait_clk(30);
        chk("ovr.hold", bus.dout_o, 8'h01);
        bus.ready_i = 1'b1;
        wait_clk(40);
        chk_stream("drain");
        chk("drain.count", bus.count_o, 0);

        // Second stop bit low: frame error, break, then recovery.
        f0 = ferr_n;
        send(8'h3C, 1'b1);
        line(1'b0, BITCLK);
        line(1'b1, 2 * BITCLK);
        chk("ferr.pulses", ferr_n - f0, 1);
        chk("ferr.count", bus.count_o, 0);
        exp_q.push_back(8'h55);
        send(8'h55);
        wait_clk(40);
        chk_stream("after_ferr");
        chk("after_ferr.pulses", ferr_n - f0, 1);

        // Short low glitch: rejected at the start-bit midpoint.
        line(1'b0, 30);
        line(1'b1, 300);
        chk("glitch.count", bus.count_o, 0);
        chk("glitch.ferr", ferr_n - f0, 1);
        chk_stream("glitch");

        // Reset in the middle of a frame with one byte already queued.
        bus.ready_i = 1'b0;
        send(8'h11);
        wait_clk(40);
        chk("prerst.count", bus.count_o, 1);
        fork
            send(8'hFF);
            begin
                wait_clk(4 * BITCLK);
                rst = 1'b1;
                wait_clk(1);
                rst = 1'b0;
                chk("midrst.dout", bus.dout_o, 8'h00);
                chk("midrst.valid", bus.valid_o, 1'b0);
                chk("midrst.count", bus.count_o, 0);
                chk("midrst.ferr", bus.frame_err_o, 1'b0);
            end
        join
        wait_clk(2 * BITCLK);
        got_q.delete();
        bus.ready_i = 1'b1;
        exp_q.push_back(8'h81);
        send(8'h81);
        wait_clk(40);
        chk_stream("post_rst");

        // Random bytes, random gaps, randomly stalling consumer.
        f0 = ferr_n;
        o0 = ovr_n;
        done = 0;
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    b = 8'($urandom);
                    exp_q.push_back(b);
                    send(b);
                    line(1'b1, $urandom_range(0, 200));
                end
                done = 1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #2;
                    bus.ready_i = ($urandom_range(0, 3) != 0);
                end
            end
        join
        bus.ready_i = 1'b1;
        wait_clk(40);
        chk_stream("rand");
        chk("rand.ferr", ferr_n - f0, 0);
        chk("rand.ovr", ovr_n - o0, 0);

`ifdef UART_RX_PARITY_EN
        f0 = ferr_n;
        send(8'h07, 1'b0, 1'b1);
        wait_clk(40);
        chk("par.bad_ferr", ferr_n - f0, 1);
        chk_stream("par.bad");
        exp_q.push_back(8'h07);
        send(8'h07);
        wait_clk(40);
        chk("par.good_ferr", ferr_n - f0, 1);
        chk_stream("par.good");
`endif

        chk("pulse.width", long_n, 0);
        chk("dout.hold", hold_bad, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
